// File: rtl/asm18_debug_pkg.sv
// Shared definitions for the asm18 processor debug/wait interface and the
// host-side dump controller that walks it.
package asm18_debug_pkg;

    localparam int DEBUG_ADDR_W  = 4;
    localparam int DEBUG_ADDR_IP = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SEND,
        ST_HOLD,
        ST_RESUME,
        ST_RELEASE
    } dump_state_t;

    // Read request presented to the processor's debug port.
    typedef struct packed {
        logic                    get_param;
        logic [DEBUG_ADDR_W-1:0] reg_addr;
    } debug_req_t;

endpackage

// File: rtl/debug_dump_controller.sv
// Dumps r0..r(NUM_REGS-1) and ip over a valid/ready stream while the core is
// parked in wait, then issues a one-cycle resume pulse on host request.
module debug_dump_controller
    import asm18_debug_pkg::*;
#(
    parameter int WORD_SIZE     = 18,
    parameter int NUM_REGS      = DEBUG_ADDR_IP,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_wait_for_continue,
    output logic                    o_wait_continue_execution,
    output logic                    o_debug_get_param,
    output logic [DEBUG_ADDR_W-1:0] o_debug_reg_addr,
    input  logic [WORD_SIZE-1:0]    i_debug_data_in,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [WORD_SIZE-1:0]    o_out_data,
    output logic [DEBUG_ADDR_W-1:0] o_out_index,
    output logic                    o_out_last,
    input  logic                    i_continue_req,
    output logic                    o_halted
);

    localparam logic [3:0]              LP_RELOAD   = 4'(SETTLE_CYCLES - 1);
    localparam logic [DEBUG_ADDR_W-1:0] LP_LAST_IDX = DEBUG_ADDR_W'(NUM_REGS);

    dump_state_t             r_state;
    debug_req_t              r_dbg;
    logic [DEBUG_ADDR_W-1:0] r_index;
    logic [3:0]              r_cnt;
    logic                    r_pending;
    logic                    r_wce;
    logic                    r_out_valid;
    logic [WORD_SIZE-1:0]    r_out_data;
    logic [DEBUG_ADDR_W-1:0] r_out_index;
    logic                    r_out_last;
    logic                    r_halted;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_dbg       <= '0;
            r_index     <= '0;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_wce       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_wce <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_wait_for_continue) begin
                        r_state <= ST_SETTLE;
                        r_index <= '0;
                        r_cnt   <= LP_RELOAD;
                        r_dbg   <= '{get_param: 1'b1, reg_addr: '0};
                    end
                end
                ST_SETTLE: begin
                    if (i_continue_req) r_pending <= 1'b1;
                    // Core left wait mid-dump: abandon without emitting more words.
                    if (!i_wait_for_continue) begin
                        r_state   <= ST_IDLE;
                        r_dbg     <= '0;
                        r_pending <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_out_data  <= i_debug_data_in;
                        r_out_index <= r_index;
                        r_out_last  <= (r_index == LP_LAST_IDX);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SEND;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SEND: begin
                    if (i_continue_req) r_pending <= 1'b1;
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!i_wait_for_continue) begin
                            r_state   <= ST_IDLE;
                            r_dbg     <= '0;
                            r_pending <= 1'b0;
                        end else if (r_index == LP_LAST_IDX) begin
                            r_state  <= ST_HOLD;
                            r_dbg    <= '0;
                            r_halted <= 1'b1;
                        end else begin
                            r_index <= r_index + 4'd1;
                            r_dbg   <= '{get_param: 1'b1, reg_addr: r_index + 4'd1};
                            r_cnt   <= LP_RELOAD;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_continue_req || r_pending) begin
                        r_state   <= ST_RESUME;
                        r_halted  <= 1'b0;
                        r_pending <= 1'b0;
                        r_wce     <= 1'b1;
                    end
                end
                ST_RESUME: r_state <= ST_RELEASE;
                ST_RELEASE: begin
                    if (!i_wait_for_continue) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_wait_continue_execution = r_wce;
    assign o_debug_get_param         = r_dbg.get_param;
    assign o_debug_reg_addr          = r_dbg.reg_addr;
    assign o_out_valid               = r_out_valid;
    assign o_out_data                = r_out_data;
    assign o_out_index               = r_out_index;
    assign o_out_last                = r_out_last;
    assign o_halted                  = r_halted;

endmodule

// File: tb/tb_debug_dump_controller.sv
// Randomized bench: a register-file model answers debug reads, and every
// accepted word is checked against the expected r0..r7, ip sequence.
module tb_debug_dump_controller;

    localparam int W  = 18;
    localparam int NR = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wfc = 1'b0;
    logic         ready = 1'b0;
    logic         creq = 1'b0;
    logic [W-1:0] ddata;
    logic         wce, dgp, ovalid, olast, halted;
    logic [3:0]   addr, oidx;
    logic [W-1:0] odata;

    logic [W-1:0] regs [0:NR];
    int checks = 0, fails = 0;
    int exp_idx = 0, acc_cnt = 0, cyc = 0;

    debug_dump_controller #(.WORD_SIZE(W), .NUM_REGS(NR), .SETTLE_CYCLES(1)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_wait_for_continue(wfc),
        .o_wait_continue_execution(wce), .o_debug_get_param(dgp),
        .o_debug_reg_addr(addr), .i_debug_data_in(ddata),
        .o_out_valid(ovalid), .i_out_ready(ready), .o_out_data(odata),
        .o_out_index(oidx), .o_out_last(olast), .i_continue_req(creq),
        .o_halted(halted)
    );

    always #5 clk = ~clk;

    // Processor debug port: combinational read of the register file.
    always_comb ddata = (int'(addr) <= NR) ? regs[addr] : '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // One clock; checks any word handed over on that edge against the model.
    task automatic tick();
        logic pv, pr, pl;
        logic [W-1:0] pd;
        logic [3:0] pi;
        pv = ovalid; pr = ready; pd = odata; pi = oidx; pl = olast;
        @(posedge clk); #1;
        cyc++;
        if (pv && pr) begin
            chk("word_idx", pi, exp_idx);
            chk("word_data", pd, regs[exp_idx]);
            chk("word_last", pl, exp_idx == NR);
            if (exp_idx == NR) chk("halt_after_last", halted, 1);
            acc_cnt++;
            exp_idx++;
        end else if (pv) begin
            chk("stall_valid", ovalid, 1);
            chk("stall_data", odata, pd);
            chk("stall_idx", oidx, pi);
        end
        if (dgp) chk("addr_track", addr, exp_idx);
        else     chk("addr_zero", addr, 0);
    endtask

    task automatic set_regs(input bit fixed);
        for (int i = 0; i <= NR; i++)
            regs[i] = fixed ? W'(i + 1) : W'($urandom);
        if (fixed) regs[NR] = 18'h0002A;
    endtask

    task automatic start_dump();
        exp_idx = 0; acc_cnt = 0;
        wfc = 1'b1;
        tick();
        chk("start_dgp", dgp, 1);
        chk("start_novalid", ovalid, 0);
    endtask

    task automatic run_dump(input int mode, input int cont_word);
        int guard = 0;
        bit sent = 1'b0;
        while (!halted && guard < 400) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = (cyc % 3 == 0);
                default: ready = 1'($urandom);
            endcase
            creq = (!sent && cont_word >= 0 && acc_cnt >= cont_word);
            if (creq) sent = 1'b1;
            tick();
            creq = 1'b0;
            guard++;
        end
        chk("dump_halted", halted, 1);
        chk("word_count", acc_cnt, NR + 1);
    endtask

    task automatic resume(input bit pending);
        if (!pending) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("hold_halted", halted, 1);
                chk("hold_no_wce", wce, 0);
            end
            creq = 1'b1;
        end
        tick();
        creq = 1'b0;
        chk("wce_pulse", wce, 1);
        chk("halted_clr", halted, 0);
        tick();
        chk("wce_one_cycle", wce, 0);
        repeat (3) begin
            tick();
            chk("release_novalid", ovalid, 0);
            chk("release_nodgp", dgp, 0);
            chk("release_no_wce", wce, 0);
        end
        wfc = 1'b0;
        tick();
        tick();
        chk("idle_novalid", ovalid, 0);
    endtask

    initial begin
        bit last_seen;
        int guard;
        set_regs(1'b1);
        #2;
        chk("rst_valid", ovalid, 0);
        chk("rst_dgp", dgp, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wce", wce, 0);
        chk("rst_addr", addr, 0);
        chk("rst_last", olast, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_valid", ovalid, 0);

        // Fixed program, ready tied high: latency and full sequence.
        ready = 1'b1;
        start_dump();
        tick();
        chk("first_valid", ovalid, 1);
        chk("first_index", oidx, 0);
        run_dump(0, -1);
        resume(1'b0);

        // Ready 1-of-3, early continue at word 3, then a second dump.
        start_dump();
        run_dump(1, 3);
        resume(1'b1);
        set_regs(1'b0);
        start_dump();
        run_dump(0, -1);
        resume(1'b0);

        // Async reset while word 4 is stalled in SEND.
        set_regs(1'b0);
        start_dump();
        guard = 0;
        while (!(ovalid && oidx == 4) && guard < 100) begin
            ready = 1'b1; tick(); guard++;
        end
        chk("reached_word4", oidx, 4);
        ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ovalid, 0);
        chk("mid_rst_dgp", dgp, 0);
        chk("mid_rst_halted", halted, 0);
        wfc = 1'b0; exp_idx = 0; acc_cnt = 0;
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", ovalid, 0);
        start_dump();
        run_dump(2, -1);
        resume(1'b0);

        // Core leaves wait during SETTLE of index 5.
        set_regs(1'b0);
        start_dump();
        guard = 0;
        ready = 1'b1;
        while (!(exp_idx == 5 && dgp && !ovalid) && guard < 100) begin
            tick(); guard++;
        end
        chk("settle5_addr", addr, 5);
        wfc = 1'b0;
        tick();
        chk("abort_dgp", dgp, 0);
        chk("abort_valid", ovalid, 0);
        last_seen = 1'b0;
        repeat (4) begin
            tick();
            last_seen |= olast | ovalid;
        end
        chk("abort_no_words", last_seen, 0);
        chk("abort_halted", halted, 0);

        // Randomized dumps.
        repeat (4) begin
            int cw;
            set_regs(1'b0);
            cw = int'($urandom_range(0, 9)) - 1;
            start_dump();
            run_dump(int'($urandom_range(1, 2)), cw);
            resume(cw >= 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
